// File: rtl/key_remap_writer_pkg.sv
// Shared constants, FSM state and UI phase encodings for the key remap writer.
package key_remap_writer_pkg;

  localparam int NOTE_KEY_BITS   = 7;
  localparam int TIMEOUT_DEFAULT = 100000000;
  localparam int IDX_W           = $clog2(NOTE_KEY_BITS);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SRC      = 3'd1,
    ST_SRC_REL  = 3'd2,
    ST_DST      = 3'd3,
    ST_DST_REL  = 3'd4,
    ST_CONFIRM  = 3'd5,
    ST_WRITE    = 3'd6,
    ST_RESTORE  = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_SOURCE = 2'd1,
    PH_TARGET = 2'd2,
    PH_COMMIT = 2'd3
  } phase_t;

  // UI phase shown to the user for each FSM state; restore is reported as
  // a commit-type activity.
  function automatic phase_t phase_of(input state_t s);
    phase_t p;
    case (s)
      ST_IDLE:               p = PH_IDLE;
      ST_SRC, ST_SRC_REL:    p = PH_SOURCE;
      ST_DST, ST_DST_REL:    p = PH_TARGET;
      default:               p = PH_COMMIT;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/key_remap_writer_if.sv
// Write port towards the key-map RAM: strobe, one-hot entry select, one-hot data.
interface key_remap_writer_if;
  import key_remap_writer_pkg::*;

  logic                     ram_rw;
  logic [NOTE_KEY_BITS-1:0] ram_addr;
  logic [NOTE_KEY_BITS-1:0] ram_data;

  modport master (output ram_rw, output ram_addr, output ram_data);
  modport slave  (input  ram_rw, input  ram_addr, input  ram_data);
endinterface

// File: rtl/key_remap_writer_onehot_check.sv
// Classifies a key vector as zero, exactly-one-hot or multi-hot (chord).
module onehot_check
  import key_remap_writer_pkg::*;
#(
  parameter int W = NOTE_KEY_BITS
) (
  input  logic [W-1:0] vec,
  output logic         is_zero,
  output logic         is_onehot,
  output logic         is_multi
);

  // hit[i]: bit i is set and at least one other bit is set as well.
  logic [W-1:0] hit;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_hit
      localparam logic [W-1:0] SELF = {{(W-1){1'b0}}, 1'b1} << gi;
      assign hit[gi] = vec[gi] & (|(vec & ~SELF));
    end
  endgenerate

  assign is_zero   = ~(|vec);
  assign is_multi  = |hit;
  assign is_onehot = (|vec) & ~(|hit);

endmodule

// File: rtl/key_remap_writer.sv
// Key remap writer: walks the user through source/target key selection and
// writes the binding (or the identity map) into the one-hot key-map RAM.
module key_remap_writer
  import key_remap_writer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     remap_en,
  input  logic [NOTE_KEY_BITS-1:0] keys,
  input  logic                     confirm,
  input  logic                     cancel,
  input  logic                     restore,
  key_remap_writer_if.master       ram,
  output logic                     busy,
  output logic [1:0]               phase,
  output logic                     done,
  output logic                     err
);

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NOTE_KEY_BITS - 1);
  localparam logic [NOTE_KEY_BITS-1:0] BIT0 = {{(NOTE_KEY_BITS-1){1'b0}}, 1'b1};

  state_t                   state_reg, state_next;
  logic [NOTE_KEY_BITS-1:0] src_reg, src_next;
  logic [NOTE_KEY_BITS-1:0] dst_reg, dst_next;
  logic [NOTE_KEY_BITS-1:0] keys_prev_reg;
  logic                     chord_reg, chord_next;
  logic [IDX_W-1:0]         idx_reg, idx_next;
  logic [31:0]              cnt_reg, cnt_next;

  logic                     ram_rw_reg, ram_rw_next;
  logic [NOTE_KEY_BITS-1:0] ram_addr_reg, ram_addr_next;
  logic [NOTE_KEY_BITS-1:0] ram_data_reg, ram_data_next;
  logic                     busy_reg, done_reg, done_next, err_reg, err_next;
  logic [1:0]               phase_reg;

  logic keys_zero, keys_onehot, keys_multi;
  logic press, timed_state, timeout_hit;

  onehot_check #(.W(NOTE_KEY_BITS)) u_key_check (
    .vec       (keys),
    .is_zero   (keys_zero),
    .is_onehot (keys_onehot),
    .is_multi  (keys_multi)
  );

  // A press is a clean transition from no keys to exactly one key.
  assign press       = (keys_prev_reg == '0) && keys_onehot;
  assign timed_state = (state_reg == ST_SRC_REL) || (state_reg == ST_DST) ||
                       (state_reg == ST_DST_REL) || (state_reg == ST_CONFIRM);
  assign timeout_hit = timed_state && (cnt_reg == TO_LAST);

  // Next-state logic; priority is mode exit, restore, cancel, confirm,
  // timeout, then key events.
  always_comb begin
    state_next = state_reg;
    src_next   = src_reg;
    dst_next   = dst_reg;
    chord_next = chord_reg;
    idx_next   = '0;
    done_next  = 1'b0;
    err_next   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        chord_next = 1'b0;
        if (remap_en) state_next = ST_SRC;
      end
      ST_WRITE: begin
        state_next = ST_SRC;
        done_next  = 1'b1;
      end
      ST_RESTORE: begin
        if (idx_reg == IDX_LAST) begin
          state_next = ST_SRC;
          done_next  = 1'b1;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      default: begin
        if (!remap_en) begin
          state_next = ST_IDLE;
          chord_next = 1'b0;
        end else if (restore && (state_reg == ST_SRC || state_reg == ST_DST ||
                                 state_reg == ST_CONFIRM)) begin
          state_next = ST_RESTORE;
          chord_next = 1'b0;
        end else if (cancel) begin
          state_next = ST_SRC;
          err_next   = 1'b1;
          chord_next = 1'b0;
        end else if (confirm && state_reg == ST_CONFIRM) begin
          state_next = ST_WRITE;
        end else if (timeout_hit) begin
          state_next = ST_SRC;
          err_next   = 1'b1;
          chord_next = 1'b0;
        end else begin
          case (state_reg)
            ST_SRC, ST_DST: begin
              if (chord_reg) begin
                if (keys_zero) chord_next = 1'b0;
              end else if (keys_multi) begin
                err_next   = 1'b1;
                chord_next = 1'b1;
              end else if (press) begin
                if (state_reg == ST_SRC) begin
                  src_next   = keys;
                  state_next = ST_SRC_REL;
                end else begin
                  dst_next   = keys;
                  state_next = ST_DST_REL;
                end
              end
            end
            ST_SRC_REL: if (keys_zero) state_next = ST_DST;
            ST_DST_REL: if (keys_zero) state_next = ST_CONFIRM;
            default: ;
          endcase
        end
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state so every
  // output is a plain register.
  always_comb begin
    ram_rw_next   = 1'b0;
    ram_addr_next = '0;
    ram_data_next = '0;
    cnt_next      = cnt_reg + 32'd1;
    if (state_next == ST_WRITE) begin
      ram_rw_next   = 1'b1;
      ram_addr_next = dst_next;
      ram_data_next = src_next;
    end else if (state_next == ST_RESTORE) begin
      ram_rw_next   = 1'b1;
      ram_addr_next = BIT0 << idx_next;
      ram_data_next = BIT0 << idx_next;
    end
    if (state_next != state_reg || keys != keys_prev_reg || state_reg == ST_IDLE) begin
      cnt_next = '0;
    end
  end

  // State, captured keys and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      src_reg       <= '0;
      dst_reg       <= '0;
      keys_prev_reg <= '0;
      chord_reg     <= 1'b0;
      idx_reg       <= '0;
      cnt_reg       <= '0;
      ram_rw_reg    <= 1'b0;
      ram_addr_reg  <= '0;
      ram_data_reg  <= '0;
      busy_reg      <= 1'b0;
      phase_reg     <= PH_IDLE;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      src_reg       <= src_next;
      dst_reg       <= dst_next;
      keys_prev_reg <= keys;
      chord_reg     <= chord_next;
      idx_reg       <= idx_next;
      cnt_reg       <= cnt_next;
      ram_rw_reg    <= ram_rw_next;
      ram_addr_reg  <= ram_addr_next;
      ram_data_reg  <= ram_data_next;
      busy_reg      <= (state_next != ST_IDLE);
      phase_reg     <= phase_of(state_next);
      done_reg      <= done_next;
      err_reg       <= err_next;
    end
  end

  assign ram.ram_rw   = ram_rw_reg;
  assign ram.ram_addr = ram_addr_reg;
  assign ram.ram_data = ram_data_reg;
  assign busy         = busy_reg;
  assign phase        = phase_reg;
  assign done         = done_reg;
  assign err          = err_reg;

endmodule
